// File: rtl/paged_sram_ctrl_if.sv
// CPU bus seen by the paged SRAM controller: address/data/direction with a
// req/ready stretch handshake.
interface paged_sram_ctrl_if;
  logic [15:0] AD;
  logic [7:0]  DI;
  logic [7:0]  DO;
  logic        rw;
  logic        req;
  logic        ready;

  modport master (output AD, DI, rw, req, input DO, ready);
  modport slave  (input AD, DI, rw, req, output DO, ready);
endinterface

// File: rtl/paged_sram_ctrl.sv
// Maps CPU accesses onto a 512 KB async SRAM through a paged 16 KB window and an
// optional SRAM-backed top region; wait states stretch the CPU via ready.
// Optional write protection per page: define PAGED_SRAM_WPROT_EN.
module paged_sram_ctrl #(
  parameter int         WAIT_STATES = 2,
  parameter logic [1:0] WIN_SEL     = 2'b10,
  parameter logic [4:0] TOP_PAGE    = 5'h1F
) (
  input  logic               clk,
  input  logic               rst,
  paged_sram_ctrl_if.slave   cpu,
  input  logic [4:0]         page,
  input  logic               bram_disable,
  output logic               bram_cs,
  output logic [18:0]        sram_a,
  output logic [7:0]         sram_d_o,
  output logic               sram_d_oe,
  input  logic [7:0]         sram_d_i,
  output logic               sram_ce_n,
  output logic               sram_oe_n,
  output logic               sram_we_n
`ifdef PAGED_SRAM_WPROT_EN
  ,
  input  logic [31:0]        wp_mask,
  output logic               wp_fault
`endif
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  localparam logic [3:0] CNT_INIT = 4'(WAIT_STATES - 1);

  state_t      state, state_d;
  logic [3:0]  cnt, cnt_d;
  logic [18:0] a_d;
  logic [7:0]  dout_d, do_q, do_d;
  logic        ce_d, oe_d, we_d, doe_d;
  logic        win, top, hit, prot;
  logic [4:0]  pg;

  assign win     = cpu.AD[15:14] == WIN_SEL;
  assign top     = cpu.AD[15:14] == 2'b11;
  assign hit     = cpu.req & (win | (top & bram_disable));
  assign pg      = win ? page : TOP_PAGE;
  assign bram_cs = cpu.req & top & ~bram_disable;
  assign cpu.ready = ((state == IDLE) & ~hit) | (state == DONE);
  assign cpu.DO  = do_q;

`ifdef PAGED_SRAM_WPROT_EN
  logic prot_q, prot_d, fault_d;
  assign prot = ~cpu.rw & wp_mask[pg];
`else
  assign prot = 1'b0;
`endif

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    a_d     = sram_a;
    dout_d  = sram_d_o;
    do_d    = do_q;
    ce_d    = sram_ce_n;
    oe_d    = sram_oe_n;
    we_d    = sram_we_n;
    doe_d   = sram_d_oe;
`ifdef PAGED_SRAM_WPROT_EN
    prot_d  = prot_q;
    fault_d = 1'b0;
`endif
    case (state)
      IDLE: if (hit) begin
        a_d     = {pg, cpu.AD[13:0]};
        dout_d  = cpu.DI;
        ce_d    = 1'b0;
        oe_d    = ~cpu.rw;
        // A protected write keeps its slot timing but never drives the bus.
        we_d    = cpu.rw | prot;
        doe_d   = ~cpu.rw & ~prot;
        cnt_d   = CNT_INIT;
        state_d = ACCESS;
`ifdef PAGED_SRAM_WPROT_EN
        prot_d  = prot;
`endif
      end
      ACCESS: begin
        if (cnt == 4'd0) begin
          if (!sram_oe_n) do_d = sram_d_i;
          // ce_n, d_oe and address stay put one more cycle for hold time.
          we_d    = 1'b1;
          oe_d    = 1'b1;
          state_d = DONE;
`ifdef PAGED_SRAM_WPROT_EN
          fault_d = prot_q;
`endif
        end else begin
          cnt_d = cnt - 4'd1;
        end
      end
      DONE: begin
        ce_d    = 1'b1;
        doe_d   = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      sram_a    <= '0;
      sram_d_o  <= '0;
      do_q      <= '0;
      sram_ce_n <= 1'b1;
      sram_oe_n <= 1'b1;
      sram_we_n <= 1'b1;
      sram_d_oe <= 1'b0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      sram_a    <= a_d;
      sram_d_o  <= dout_d;
      do_q      <= do_d;
      sram_ce_n <= ce_d;
      sram_oe_n <= oe_d;
      sram_we_n <= we_d;
      sram_d_oe <= doe_d;
    end
  end

`ifdef PAGED_SRAM_WPROT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prot_q   <= 1'b0;
      wp_fault <= 1'b0;
    end else begin
      prot_q   <= prot_d;
      wp_fault <= fault_d;
    end
  end
`endif

endmodule

// File: tb/tb_paged_sram_ctrl.sv
// Randomized bench for paged_sram_ctrl: SRAM device model on the pins plus a
// reference memory updated from address-mapping rules.
module tb_paged_sram_ctrl;
  localparam int WS = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  paged_sram_ctrl_if cpu();
  logic [4:0]  page;
  logic        bram_disable, bram_cs;
  logic [18:0] sram_a;
  logic [7:0]  sram_d_o, sram_d_i;
  logic        sram_d_oe, sram_ce_n, sram_oe_n, sram_we_n;
`ifdef PAGED_SRAM_WPROT_EN
  logic [31:0] wp_mask = 32'h0;
  logic        wp_fault;
`endif

  paged_sram_ctrl #(.WAIT_STATES(WS)) dut (
    .clk(clk), .rst(rst), .cpu(cpu), .page(page), .bram_disable(bram_disable),
    .bram_cs(bram_cs), .sram_a(sram_a), .sram_d_o(sram_d_o), .sram_d_oe(sram_d_oe),
    .sram_d_i(sram_d_i), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n)
`ifdef PAGED_SRAM_WPROT_EN
    , .wp_mask(wp_mask), .wp_fault(wp_fault)
`endif
  );

  logic [7:0] mem     [0:524287];
  logic [7:0] ref_mem [0:524287];
  int vectors = 0, miscompares = 0;
  logic [7:0] last_do;

  assign sram_d_i = mem[sram_a];
  always @(posedge clk) if (!sram_ce_n && !sram_we_n && sram_d_oe) mem[sram_a] = sram_d_o;

  function automatic logic [7:0] init_val(input int a);
    return 8'(a ^ (a >> 8) ^ (a >> 16) ^ 8'h5A);
  endfunction

  task automatic idle_bus();
    @(negedge clk);
    cpu.req = 1'b0;
  endtask

  // One CPU bus cycle; expectations come from the address-map rules.
  task automatic access(input logic [15:0] ad, input logic [7:0] di, input logic rd,
                        input logic [4:0] pg, input logic bd, input logic chg,
                        input logic [4:0] pg_mid, input logic [31:0] wpm);
    logic hit, prot, bad_a, bad_doe, done;
    logic [18:0] ea;
    logic [7:0] exp_do;
    int stalls, we_cnt, oe_cnt, ce_cnt, fault_cnt;
    hit  = (ad[15:14] == 2'b10) || (ad[15:14] == 2'b11 && bd);
    ea   = {(ad[15:14] == 2'b10) ? pg : 5'h1F, ad[13:0]};
    prot = 1'b0;
`ifdef PAGED_SRAM_WPROT_EN
    prot = hit && !rd && wpm[ea[18:14]];
`endif
    @(negedge clk);
`ifdef PAGED_SRAM_WPROT_EN
    wp_mask = wpm;
`endif
    cpu.AD = ad; cpu.DI = di; cpu.rw = rd; cpu.req = 1'b1;
    page = pg; bram_disable = bd;
    stalls = 0; we_cnt = 0; oe_cnt = 0; ce_cnt = 0; fault_cnt = 0;
    bad_a = 1'b0; bad_doe = 1'b0; done = 1'b0;
    #1;
    vectors++;
    if (bram_cs !== (ad[15:14] == 2'b11 && !bd)) begin
      miscompares++;
      $display("FAIL bram_cs ad=%h bd=%0d: got %0d want %0d", ad, bd, bram_cs, ad[15:14] == 2'b11 && !bd);
    end
    for (int c = 0; c < 40; c++) begin
      if (!sram_we_n) we_cnt++;
      if (!sram_oe_n) oe_cnt++;
      if (!sram_ce_n) ce_cnt++;
      if (!sram_ce_n && sram_a !== ea) bad_a = 1'b1;
      if (!sram_we_n && !sram_d_oe) bad_doe = 1'b1;
`ifdef PAGED_SRAM_WPROT_EN
      if (wp_fault) fault_cnt++;
`endif
      if (cpu.ready) begin done = 1'b1; break; end
      stalls++;
      if (chg && stalls == 2) begin page = pg_mid; bram_disable = ~bd; end
      @(negedge clk); #1;
    end
    exp_do = (hit && rd) ? ref_mem[ea] : last_do;
    vectors++;
    if (!done) begin
      miscompares++;
      $display("FAIL ready_timeout ad=%h: ready never rose within 40 cycles", ad);
    end
    vectors++;
    if (stalls != (hit ? WS + 1 : 0)) begin
      miscompares++;
      $display("FAIL stall_cycles ad=%h: got %0d want %0d", ad, stalls, hit ? WS + 1 : 0);
    end
    vectors++;
    if (we_cnt != ((hit && !rd && !prot) ? WS : 0) || oe_cnt != ((hit && rd) ? WS : 0)) begin
      miscompares++;
      $display("FAIL strobes ad=%h rd=%0d: got we=%0d oe=%0d want we=%0d oe=%0d", ad, rd,
               we_cnt, oe_cnt, (hit && !rd && !prot) ? WS : 0, (hit && rd) ? WS : 0);
    end
    vectors++;
    if (ce_cnt != (hit ? WS + 1 : 0) || bad_a || bad_doe) begin
      miscompares++;
      $display("FAIL ce_addr ad=%h: got ce_cycles=%0d bad_addr=%0d bad_doe=%0d want ce_cycles=%0d addr=%h",
               ad, ce_cnt, bad_a, bad_doe, hit ? WS + 1 : 0, ea);
    end
    vectors++;
    if (cpu.DO !== exp_do) begin
      miscompares++;
      $display("FAIL read_data ad=%h rd=%0d: got %h want %h", ad, rd, cpu.DO, exp_do);
    end
`ifdef PAGED_SRAM_WPROT_EN
    vectors++;
    if (fault_cnt != (prot ? 1 : 0)) begin
      miscompares++;
      $display("FAIL wp_fault ad=%h: got %0d pulses want %0d", ad, fault_cnt, prot ? 1 : 0);
    end
`endif
    if (hit && !rd && !prot) ref_mem[ea] = di;
    last_do = exp_do;
  endtask

  task automatic test_reset();
    #1;
    vectors++;
    if ({sram_ce_n, sram_oe_n, sram_we_n, sram_d_oe} !== 4'b1110 || sram_a !== 19'h0 ||
        sram_d_o !== 8'h0 || cpu.DO !== 8'h0) begin
      miscompares++;
      $display("FAIL reset_state: got ce/oe/we/oe=%b a=%h d=%h DO=%h want 1110 0 0 0",
               {sram_ce_n, sram_oe_n, sram_we_n, sram_d_oe}, sram_a, sram_d_o, cpu.DO);
    end
    @(negedge clk); rst = 1'b0; #1;
    vectors++;
    if (cpu.ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_ready: got %0d want 1", cpu.ready);
    end
    last_do = 8'h0;
  endtask

  task automatic test_write();
    access(16'h8123, 8'hA5, 1'b0, 5'h05, 1'b0, 1'b0, 5'h0, 32'h0);
    vectors++;
    if (sram_a !== 19'h14123 || sram_d_o !== 8'hA5) begin
      miscompares++;
      $display("FAIL write_addr: got a=%h d=%h want 14123 a5", sram_a, sram_d_o);
    end
    idle_bus();
  endtask

  task automatic test_read();
    mem[19'h14123] = 8'h3C; ref_mem[19'h14123] = 8'h3C;
    access(16'h8123, 8'h00, 1'b1, 5'h05, 1'b0, 1'b0, 5'h0, 32'h0);
    vectors++;
    if (cpu.DO !== 8'h3C) begin
      miscompares++;
      $display("FAIL read_3c: got %h want 3c", cpu.DO);
    end
    idle_bus();
  endtask

  task automatic test_bram();
    access(16'hF000, 8'h00, 1'b1, 5'h05, 1'b0, 1'b0, 5'h0, 32'h0);
    idle_bus();
    access(16'hF000, 8'h00, 1'b1, 5'h05, 1'b1, 1'b0, 5'h0, 32'h0);
    vectors++;
    if (sram_a !== 19'h7F000) begin
      miscompares++;
      $display("FAIL top_page_addr: got %h want 7f000", sram_a);
    end
    idle_bus();
  endtask

  task automatic test_page_change();
    access(16'h8010, 8'h77, 1'b0, 5'h05, 1'b0, 1'b1, 5'h06, 32'h0);
    vectors++;
    if (sram_a !== 19'h14010) begin
      miscompares++;
      $display("FAIL page_change_inflight: got %h want 14010", sram_a);
    end
    access(16'h8010, 8'h00, 1'b1, 5'h06, 1'b0, 1'b0, 5'h0, 32'h0);
    vectors++;
    if (sram_a !== 19'h18010) begin
      miscompares++;
      $display("FAIL page_change_next: got %h want 18010", sram_a);
    end
    idle_bus();
  endtask

  task automatic test_back_to_back();
    access(16'h8200, 8'hC3, 1'b0, 5'h07, 1'b0, 1'b0, 5'h0, 32'h0);
    access(16'h8200, 8'h00, 1'b1, 5'h07, 1'b0, 1'b0, 5'h0, 32'h0);
    vectors++;
    if (cpu.DO !== 8'hC3) begin
      miscompares++;
      $display("FAIL back_to_back: got %h want c3", cpu.DO);
    end
    idle_bus();
  endtask

  task automatic test_random();
    logic [1:0] seg;
    logic [4:0] pg;
    for (int i = 0; i < 80; i++) begin
      seg = 2'($urandom_range(0, 3));
      pg  = ($urandom_range(0, 4) == 0) ? 5'h1F : 5'($urandom_range(4, 7));
      access({seg, 14'($urandom_range(0, 7))}, 8'($urandom), 1'($urandom), pg,
             1'($urandom), 1'($urandom), 5'($urandom_range(4, 7)), 32'h0000_0040);
    end
    idle_bus();
  endtask

  task automatic test_reset_mid_access();
    @(negedge clk);
    cpu.AD = 16'h8040; cpu.rw = 1'b1; cpu.req = 1'b1; page = 5'h05; bram_disable = 1'b0;
    @(negedge clk); @(negedge clk);
    #1 rst = 1'b1; cpu.req = 1'b0;
    #1;
    vectors++;
    if ({sram_ce_n, sram_oe_n, sram_we_n, sram_d_oe} !== 4'b1110) begin
      miscompares++;
      $display("FAIL reset_mid_access: got ce/oe/we/oe=%b want 1110",
               {sram_ce_n, sram_oe_n, sram_we_n, sram_d_oe});
    end
    @(negedge clk); rst = 1'b0; #1;
    vectors++;
    if (cpu.ready !== 1'b1 || cpu.DO !== 8'h0) begin
      miscompares++;
      $display("FAIL reset_release: got ready=%0d DO=%h want 1 00", cpu.ready, cpu.DO);
    end
    last_do = 8'h0;
  endtask

`ifdef PAGED_SRAM_WPROT_EN
  task automatic test_wprot();
    access(16'h8300, 8'h99, 1'b0, 5'h05, 1'b0, 1'b0, 5'h0, 32'h0000_0020);
    access(16'h8300, 8'h00, 1'b1, 5'h05, 1'b0, 1'b0, 5'h0, 32'h0000_0020);
    idle_bus();
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    cpu.req = 1'b0; cpu.AD = 16'h0; cpu.DI = 8'h0; cpu.rw = 1'b1;
    page = 5'h0; bram_disable = 1'b0; last_do = 8'h0;
    for (int a = 0; a < 524288; a++) begin
      mem[a] = init_val(a);
      ref_mem[a] = init_val(a);
    end
    test_reset();
    test_write();
    test_read();
    test_bram();
    test_page_change();
    test_back_to_back();
`ifdef PAGED_SRAM_WPROT_EN
    test_wprot();
`endif
    test_random();
    test_reset_mid_access();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
